// File: rtl/cis_line_capture_if.sv
// Ready/valid pixel stream from cis_line_capture toward the line packer / DMA.
// Each entry carries one pixel plus its colour and start/end-of-line marks.
interface cis_line_capture_if #(
    parameter int unsigned DataW = 12
) ();
    logic             valid;
    logic             ready;
    logic [DataW-1:0] data;
    logic [1:0]       color;
    logic             sol;
    logic             eol;

    modport master (output valid, data, color, sol, eol, input ready);
    modport slave  (input valid, data, color, sol, eol, output ready);
endinterface

// File: rtl/cis_line_capture.sv
// Frames one line of CIS ADC samples per SI pulse: skips settling samples, tags pixels with
// colour/SOL/EOL and buffers them in a show-ahead FIFO feeding a ready/valid stream.
module cis_line_capture #(
    parameter int unsigned PixCnt    = 2592,
    parameter int unsigned SkipCnt   = 60,
    parameter int unsigned DataW     = 12,
    parameter int unsigned FifoDepth = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 si_i,
    input  logic [1:0]           si_cnt_i,
    input  logic                 adc_valid_i,
    input  logic [DataW-1:0]     adc_data_i,
    input  logic                 clr_flags_i,
    cis_line_capture_if.master   m_if,
    output logic                 line_done_o,
    output logic [15:0]          line_cnt_o,
    output logic                 overflow_o,
    output logic                 short_line_o
);

    localparam int unsigned PixW   = (PixCnt > 1) ? $clog2(PixCnt) : 1;
    localparam int unsigned SkipW  = (SkipCnt > 1) ? $clog2(SkipCnt) : 1;
    localparam int unsigned AddrW  = $clog2(FifoDepth);
    localparam int unsigned EntryW = DataW + 4;
    localparam logic [PixW-1:0]  PixLast  = PixW'(PixCnt - 1);
    localparam logic [SkipW-1:0] SkipLast = SkipW'((SkipCnt > 0) ? SkipCnt - 1 : 0);

    typedef enum logic [1:0] {StIdle, StSkip, StCapture} state_e;

    localparam state_e StFirst = (SkipCnt > 0) ? StSkip : StCapture;

    state_e           state_q;
    logic             si_q;
    logic [1:0]       col_q;
    logic [SkipW-1:0] skip_cnt_q;
    logic [PixW-1:0]  pix_cnt_q;
    logic             line_done_q;
    logic [15:0]      line_cnt_q;
    logic             overflow_q;
    logic             short_line_q;

    logic [EntryW-1:0] mem_q [FifoDepth];
    logic [AddrW:0]    wr_ptr_q;
    logic [AddrW:0]    rd_ptr_q;

    logic              rise;
    logic              capture_hit;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              drop;
    logic [EntryW-1:0] wr_entry;
    logic [EntryW-1:0] head;

    always_comb begin
        rise        = si_i & ~si_q;
        // A rise restarts framing, so the sample in the rise cycle belongs to no line.
        capture_hit = (state_q == StCapture) & adc_valid_i & ~rise;
        fifo_empty  = (wr_ptr_q == rd_ptr_q);
        fifo_full   = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
        pop         = ~fifo_empty & m_if.ready;
        push        = capture_hit & (~fifo_full | pop);
        drop        = capture_hit & fifo_full & ~pop;
        wr_entry    = {col_q, (pix_cnt_q == '0), (pix_cnt_q == PixLast), adc_data_i};
        head        = fifo_empty ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
    end

    assign m_if.valid   = ~fifo_empty;
    assign m_if.data    = head[DataW-1:0];
    assign m_if.eol     = head[DataW];
    assign m_if.sol     = head[DataW+1];
    assign m_if.color   = head[DataW+3:DataW+2];
    assign line_done_o  = line_done_q;
    assign line_cnt_o   = line_cnt_q;
    assign overflow_o   = overflow_q;
    assign short_line_o = short_line_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            si_q         <= 1'b1;
            col_q        <= '0;
            skip_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            line_done_q  <= 1'b0;
            line_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            short_line_q <= 1'b0;
        end else begin
            si_q        <= si_i;
            line_done_q <= 1'b0;

            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_flags_i) begin
                overflow_q <= 1'b0;
            end

            if (rise && (state_q != StIdle)) begin
                short_line_q <= 1'b1;
            end else if (clr_flags_i) begin
                short_line_q <= 1'b0;
            end

            if (rise) begin
                col_q      <= si_cnt_i;
                skip_cnt_q <= '0;
                pix_cnt_q  <= '0;
                state_q    <= StFirst;
            end else begin
                case (state_q)
                    StSkip: begin
                        if (adc_valid_i) begin
                            if (skip_cnt_q == SkipLast) begin
                                state_q <= StCapture;
                            end else begin
                                skip_cnt_q <= skip_cnt_q + 1'b1;
                            end
                        end
                    end
                    StCapture: begin
                        // Counter advances even on a dropped pixel to keep SOL/EOL aligned.
                        if (adc_valid_i) begin
                            pix_cnt_q <= pix_cnt_q + 1'b1;
                            if (pix_cnt_q == PixLast) begin
                                state_q     <= StIdle;
                                line_done_q <= 1'b1;
                                line_cnt_q  <= line_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; the head is masked to zero while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wr_entry;
        end
    end

endmodule
